// File: rtl/enc_dec_pkg.sv
// Shared extended-Hamming (SECDED) layout for the encoder and decoder pipelines.
// Both sides import this package so the info-bit placement and per-mode sizes always agree.
package enc_dec_pkg;

  localparam int CW_WIDTH   = 32;
  localparam int INFO_WIDTH = 26;
  localparam int PAR_WIDTH  = 6;
  // Hamming check bits excluding the overall-parity bit in the widest mode.
  localparam int HAM_BITS   = 5;

  localparam int K_8_4   = 4;
  localparam int P_8_4   = 4;
  localparam int N_8_4   = K_8_4 + P_8_4;
  localparam int K_16_11 = 11;
  localparam int P_16_11 = 5;
  localparam int N_16_11 = K_16_11 + P_16_11;
  localparam int K_32_26 = 26;
  localparam int P_32_26 = 6;
  localparam int N_32_26 = K_32_26 + P_32_26;

  typedef enum logic [1:0] {
    MOD_8_4     = 2'b00,
    MOD_16_11   = 2'b01,
    MOD_32_26   = 2'b10,
    MOD_ILLEGAL = 2'b11
  } mode_e;

  // Info bit idx sits at the idx-th non-power-of-two Hamming position >= 3.
  function automatic logic [4:0] info_pos(input int idx);
    int          cnt;
    logic [4:0]  res;
    cnt = 0;
    res = '0;
    for (int pos = 3; pos < CW_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == idx) res = 5'(pos);
        cnt++;
      end
    end
    return res;
  endfunction

  // Info bits covered by Hamming check bit bit_idx.
  function automatic logic [INFO_WIDTH-1:0] cover_mask(input int bit_idx);
    logic [INFO_WIDTH-1:0] m;
    logic [4:0]            pos;
    m = '0;
    for (int i = 0; i < INFO_WIDTH; i++) begin
      pos  = info_pos(i);
      m[i] = pos[bit_idx];
    end
    return m;
  endfunction

  function automatic logic [INFO_WIDTH-1:0] mask_info(input logic [INFO_WIDTH-1:0] data,
                                                      input mode_e                 mode);
    logic [INFO_WIDTH-1:0] res;
    res = '0;
    case (mode)
      MOD_8_4:   res[K_8_4-1:0]   = data[K_8_4-1:0];
      MOD_16_11: res[K_16_11-1:0] = data[K_16_11-1:0];
      MOD_32_26: res[K_32_26-1:0] = data[K_32_26-1:0];
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ham_parity_gen.sv
// Combinational SECDED parity for an already-masked info word.
// Output is p parity bits for the selected mode, zero-extended to PAR_WIDTH.
module ham_parity_gen
  import enc_dec_pkg::*;
(
  input  logic [INFO_WIDTH-1:0] data,
  input  mode_e                 mod,
  output logic [PAR_WIDTH-1:0]  parity
);

  logic [HAM_BITS-1:0] ham;
  logic                overall;

  // Unused info bits are zero, so the same coverage masks serve every mode.
  for (genvar j = 0; j < HAM_BITS; j++) begin : g_ham
    localparam logic [INFO_WIDTH-1:0] MASK = cover_mask(j);
    assign ham[j] = ^(data & MASK);
  end

  // Check bits beyond the active mode evaluate to zero, so folding all of them in is safe.
  assign overall = (^data) ^ (^ham);

  always_comb begin
    // NOTE: default first so every path assigns parity and no latch is inferred.
    parity = '0;
    case (mod)
      MOD_8_4:   parity[P_8_4-1:0]   = {overall, ham[P_8_4-2:0]};
      MOD_16_11: parity[P_16_11-1:0] = {overall, ham[P_16_11-2:0]};
      MOD_32_26: parity[P_32_26-1:0] = {overall, ham[P_32_26-2:0]};
      default:   parity = '0;
    endcase
  end

endmodule

// File: rtl/ham_enc_pipe.sv
// Two-stage pipelined extended-Hamming encoder with valid/ready on both sides.
// Emits {zero pad, info[k-1:0], parity[p-1:0]}; illegal-mode words are dropped with a mod_err pulse.
module ham_enc_pipe
  import enc_dec_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = CW_WIDTH,
  parameter int MAX_INFO_WIDTH     = INFO_WIDTH,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    mod,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          mod_err,
  output logic [CNT_WIDTH-1:0]          word_count
);

  logic                          s1_valid;
  logic [MAX_INFO_WIDTH-1:0]     s1_data;
  mode_e                         s1_mode;
  logic [PAR_WIDTH-1:0]          s1_parity;
  logic [MAX_CODEWORD_WIDTH-1:0] codeword;
  logic                          load2;
  logic                          accept;
  logic                          emit;
  logic                          s1_legal;

  assign load2    = !out_valid || out_ready;
  assign in_ready = !s1_valid || load2;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  assign s1_legal = (s1_mode != MOD_ILLEGAL);

  ham_parity_gen u_parity (
    .data   (s1_data),
    .mod    (s1_mode),
    .parity (s1_parity)
  );

  always_comb begin
    codeword = '0;
    case (s1_mode)
      MOD_8_4:   codeword[N_8_4-1:0]   = {s1_data[K_8_4-1:0],   s1_parity[P_8_4-1:0]};
      MOD_16_11: codeword[N_16_11-1:0] = {s1_data[K_16_11-1:0], s1_parity[P_16_11-1:0]};
      MOD_32_26: codeword[N_32_26-1:0] = {s1_data[K_32_26-1:0], s1_parity[P_32_26-1:0]};
      default:   codeword = '0;
    endcase
  end

  // Stage 1: masked info and its own mode, so modes can change word to word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MOD_8_4;
    end else if (accept) begin
      // NOTE: non-blocking so both stages sample pre-edge values and shift as one pipeline.
      s1_valid <= 1'b1;
      s1_data  <= mask_info(data_in, mode_e'(mod));
      s1_mode  <= mode_e'(mod);
    end else if (load2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; holds data_out stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      mod_err   <= 1'b0;
    end else begin
      mod_err <= load2 && s1_valid && !s1_legal;
      if (load2) begin
        out_valid <= s1_valid && s1_legal;
        if (s1_valid && s1_legal) data_out <= codeword;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
    end else if (emit && (word_count != {CNT_WIDTH{1'b1}})) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/ham_enc_pipe.md
Name: ham_enc_pipe

Overview:
- Pipelined extended-Hamming (SECDED) encoder that sits directly upstream of the decoder and produces the codewords it consumes.
- Takes an info word and a code mode, appends parity, and emits a systematic codeword: info in the upper bits, parity in the LSBs, zero-padded to MAX_CODEWORD_WIDTH.
- Two register stages with valid/ready backpressure on both sides, plus a saturating count of emitted codewords.

Parameters:
MAX_CODEWORD_WIDTH, 32, codeword bus width
MAX_INFO_WIDTH, 26, info bus width
CNT_WIDTH, 16, width of emitted-codeword counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
data_in  in  MAX_INFO_WIDTH  info word; bits above k for the selected mode are ignored
mod  in  2  00: (8,4), 01: (16,11), 10: (32,26), 11: illegal
in_valid  in  1  data_in/mod valid
in_ready  out  1  encoder accepts when in_valid&&in_ready
data_out  out  MAX_CODEWORD_WIDTH  codeword {zero pad, info[k-1:0], parity[p-1:0]}
out_valid  out  1  data_out valid
out_ready  in  1  downstream accepts when out_valid&&out_ready
mod_err  out  1  one-cycle pulse: an illegal-mod word was accepted
word_count  out  CNT_WIDTH  number of codewords emitted (saturating)

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear immediately regardless of clk, and all in-flight words are lost:
  - data_out=0, out_valid=0, mod_err=0, word_count=0.
  - Stage-1 valid cleared.
- Mode sizes (k info bits / p parity bits): mod 00 = 4/4, mod 01 = 11/5, mod 10 = 26/6.
- Parity definition:
  - Info bit i maps to the i-th non-power-of-two position >=3, ascending (3,5,6,7,9,...).
  - Parity bit j (j<p-1) = XOR of info bits whose position has bit j set.
  - Parity bit p-1 = XOR of all info bits and parity bits 0..p-2, so total codeword weight is even.
- Stage 1: captures data_in masked to k bits, plus mod, on accept. Stage 2 (output register): data_out = encoded word.
- Latency: 2 cycles from accept to out_valid when out_ready stays high. Throughput: 1 word/cycle.
- Handshake:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances into stage 2 under the same condition.
  - in_ready = !s1_valid || stage-2 load condition. in_ready is combinational from out_ready.
- While out_valid=1 and out_ready=0: data_out and out_valid hold stable.
  - Stage 1 holds one more word. in_ready deasserts once stage 1 is full.
- Illegal mod (11):
  - The word is accepted normally and occupies stage 1.
  - When it advances, it is discarded: out_valid is not set for it.
  - mod_err pulses for exactly one cycle.
- word_count:
  - Increments on each out_valid&&out_ready.
  - Saturates at all-ones; no wrap.
- Simultaneous accept and emit in the same cycle: both take effect with no bubble.
- Mode changes word-to-word with no gap; every word carries its own mod through the pipe.

Decomposition:
- Shared package enc_dec_pkg:
  - MAX_* widths; per-mode k, p, k+p localparams.
  - mode enum (MOD_8_4, MOD_16_11, MOD_32_26, MOD_ILLEGAL).
  - Info-position mapping function. The decoder imports the same package so both sides agree on the layout.
- One combinational sub-module, ham_parity_gen (data + mod -> parity[5:0]). It is instantiated between stage 1 and stage 2. The pipeline/handshake logic stays in ham_enc_pipe.

Test Plan:
- mod=00, data_in=4'b0001, out_ready=1 -> 2 cycles later data_out=32'h0000001B; data_in=4'hF -> 32'h000000FF.
- mod=01, data_in=11'h001 -> data_out=32'h00000033; mod=10, data_in=26'h0000001 -> data_out=32'h00000063; word_count=2.
- Back-to-back 4 words, mixed mods, out_ready held 0 for 5 cycles after the first:
  - data_out stable while stalled.
  - in_ready drops after 2 words are buffered.
  - All 4 emitted in order with correct parity, none lost or duplicated.
- mod=11 word between two legal words -> exactly two out_valid beats, mod_err high for one cycle, word_count +2.
- rst asserted mid-stream with out_valid=1 -> out_valid, data_out, word_count clear without a clock edge; first word after release has 2-cycle latency.
- Random info, all legal mods, decoded with the team's decoder model -> recovered info matches and the syndrome is zero for every word.
